// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_t          : receiver FSM states
//   UART_DATA_BITS      : data bits per frame (8N1)
//   UART_CLKS_PER_BIT   : default oversampling ratio (3.226 MHz / 115200)
//   UART_TIMEOUT_CYCLES : default silence timeout (100 ms at 3.226 MHz)
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int unsigned UART_DATA_BITS      = 8;
    localparam int unsigned UART_CLKS_PER_BIT   = 28;
    localparam int unsigned UART_TIMEOUT_CYCLES = 322600;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchroniser for an asynchronous input.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset (both flops load RESET_VAL)
//   i_d     : asynchronous input
//   o_q     : synchronised output
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_byte_rx.sv
// ---------------------------------------------------------------------------
// uart_byte_rx
// Oversampling 8N1 UART receiver. Qualifies start bits at mid-bit, samples
// data LSB first, flags framing errors, holds the last good byte as a level
// and clears it to 0x00 after a silence timeout.
//   i_clk       : UART-domain clock
//   i_rst_n     : asynchronous active-low reset
//   i_rx        : raw serial line, asynchronous, idle high
//   o_data      : last good byte (level)
//   o_valid     : one-cycle pulse when o_data takes a new good byte
//   o_frame_err : one-cycle pulse when the stop bit is sampled low
//   o_timeout   : high while the silence timeout has expired
// ---------------------------------------------------------------------------
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT   = UART_CLKS_PER_BIT,
    parameter int unsigned TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_timeout
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic            w_rx_s;
    logic            r_rx_prev;
    rx_state_t       r_state;
    rx_state_t       w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic [2:0]      r_bit_idx;
    logic [2:0]      w_bit_idx_nxt;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            w_good;
    logic            w_ferr;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_ferr;
    logic            r_timeout;
    logic [CW-1:0]   r_to_cnt;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_prev <= 1'b1;
            r_state   <= IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_rx_prev <= w_rx_s;
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_good        = 1'b0;
        w_ferr        = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Falling edge only, so a line stuck low cannot retrigger.
                if (!w_rx_s && r_rx_prev) begin
                    w_timer_nxt = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_timer == HALF_LAST) begin
                    w_timer_nxt = '0;
                    if (!w_rx_s) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = DATA;
                    end else begin
                        w_state_nxt = IDLE;     // glitch: start not held to mid-bit
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            DATA: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_nxt   = '0;
                    w_shift_nxt   = {w_rx_s, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            STOP: begin
                if (r_timer == BIT_LAST) begin
                    w_timer_nxt = '0;
                    w_state_nxt = IDLE;
                    w_good      = w_rx_s;
                    w_ferr      = !w_rx_s;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output and timeout registers. A good byte takes priority over an
    // expiry landing in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_timeout <= 1'b1;
            r_to_cnt  <= '0;
        end else begin
            r_valid <= w_good;
            r_ferr  <= w_ferr;
            if (w_good) begin
                r_data    <= r_shift;
                r_to_cnt  <= '0;
                r_timeout <= 1'b0;
            end else if (r_to_cnt == TO_LAST) begin
                r_data    <= 8'h00;
                r_timeout <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_ferr;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_uart_byte_rx.sv
module tb_uart_byte_rx;

    localparam int CPB = 8;
    localparam int TO  = 400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_timeout;

    uart_byte_rx #(
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx        (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       is_ferr;
        logic [7:0] data;
        logic       chk_fall;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_valid = 0;
    int unsigned last_valid_cyc = 0;
    logic        prev_to = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected event per o_valid / o_frame_err pulse.
    always @(negedge clk) begin
        exp_t e;
        if (o_valid || o_frame_err) begin
            if (q.size() == 0) begin
                check("unexpected_event", {30'd0, o_valid, o_frame_err}, 32'd0);
            end else begin
                e = q.pop_front();
                check("event_kind", {30'd0, o_valid, o_frame_err},
                      e.is_ferr ? 32'd1 : 32'd2);
                check("event_data", {24'd0, o_data}, {24'd0, e.data});
                if (e.chk_fall) begin
                    check("timeout_fall", {30'd0, prev_to, o_timeout}, 32'd2);
                end
            end
            if (o_valid) begin
                n_valid++;
                last_valid_cyc = cyc;
            end
        end
        prev_to = o_timeout;
    end

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one 8N1 frame starting at the current negedge.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic wait_valid(input int nv0, input string name);
        int k;
        k = 0;
        while (n_valid == nv0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({name, "_seen"}, (n_valid > nv0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          nv;
        int unsigned v;
        int unsigned xa;
        int unsigned va;

        // Reset state
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, o_data}, 32'h00);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_ferr", {31'd0, o_frame_err}, 32'd0);
        check("rst_timeout", {31'd0, o_timeout}, 32'd1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Good frame: timeout falls with the valid pulse
        q.push_back('{1'b0, 8'hA5, 1'b1});
        send_byte(8'hA5, 1'b1);
        idle(4);
        check("good_hold", {24'd0, o_data}, 32'hA5);

        // Framing error: data unchanged
        q.push_back('{1'b1, 8'hA5, 1'b0});
        send_byte(8'h3C, 1'b0);
        idle(4);
        check("ferr_hold", {24'd0, o_data}, 32'hA5);

        // Glitch, then a normal frame
        rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(12);
        check("glitch_hold", {24'd0, o_data}, 32'hA5);
        q.push_back('{1'b0, 8'h01, 1'b0});
        send_byte(8'h01, 1'b1);
        idle(4);

        // Back-to-back frames, no idle gap
        q.push_back('{1'b0, 8'h00, 1'b0});
        q.push_back('{1'b0, 8'hFF, 1'b0});
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(4);
        check("b2b_hold", {24'd0, o_data}, 32'hFF);

        // Timeout: expires exactly TO cycles after the valid pulse
        nv = n_valid;
        q.push_back('{1'b0, 8'h7E, 1'b0});
        send_byte(8'h7E, 1'b1);
        rx = 1'b1;
        wait_valid(nv, "to_byte");
        v = last_valid_cyc;
        while (cyc < v + TO - 1) @(negedge clk);
        check("to_before_flag", {31'd0, o_timeout}, 32'd0);
        check("to_before_data", {24'd0, o_data}, 32'h7E);
        @(negedge clk);
        check("to_expired_flag", {31'd0, o_timeout}, 32'd1);
        check("to_expired_data", {24'd0, o_data}, 32'h00);

        // Byte completing exactly at expiry wins
        nv = n_valid;
        xa = cyc;
        q.push_back('{1'b0, 8'h81, 1'b1});
        send_byte(8'h81, 1'b1);
        rx = 1'b1;
        wait_valid(nv, "pre_expiry_byte");
        va = last_valid_cyc;
        while (cyc < xa + TO) @(negedge clk);
        nv = n_valid;
        q.push_back('{1'b0, 8'hC3, 1'b0});
        send_byte(8'hC3, 1'b1);
        rx = 1'b1;
        wait_valid(nv, "expiry_byte");
        check("expiry_gap", last_valid_cyc - va, TO);
        check("expiry_flag", {31'd0, o_timeout}, 32'd0);
        check("expiry_data", {24'd0, o_data}, 32'hC3);
        idle(2);
        check("expiry_flag_after", {31'd0, o_timeout}, 32'd0);

        // Reset during data bit 4 of 0x55, released in the stop bit
        idle(4);
        fork
            send_byte(8'h55, 1'b1);
            begin
                repeat (44) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("midrst_data", {24'd0, o_data}, 32'h00);
                check("midrst_valid", {31'd0, o_valid}, 32'd0);
                check("midrst_ferr", {31'd0, o_frame_err}, 32'd0);
                check("midrst_timeout", {31'd0, o_timeout}, 32'd1);
                repeat (31) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        idle(100);
        check("post_rst_data", {24'd0, o_data}, 32'h00);
        check("post_rst_timeout", {31'd0, o_timeout}, 32'd1);
        check("queue_empty", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
